instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly downstream of the CPU control-unit state machine. It consumes the control unit's fetch pulse, PC pulse and 2-bit PC control code. It owns the program counter and runs a request/acknowledge read to instruction memory. It holds the fetched word in the instruction register, decodes its fields back to the control unit, and returns the one-cycle fetch-done strobe en1.

Parameters:
ADDR_W, 8, program counter and instruction memory address width (1..8)
INSTR_W, 16, instruction width; fixed field layout requires 16
RESET_PC, 0, PC value after reset and on pc_ctrl=11
TIMEOUT_CYCLES, 15, wait-cycle limit used only when FETCH_TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en_fetch_pulse  in  1  start one instruction fetch (single-cycle pulse)
en_pc_pulse  in  1  apply pc_ctrl this cycle (single-cycle pulse)
pc_ctrl  in  2  00 hold, 01 increment, 10 jump to ir[7:0], 11 load RESET_PC
mem_req  out  1  instruction read request
mem_addr  out  ADDR_W  read address, stable while mem_req=1
mem_rdata  in  INSTR_W  read data, valid when mem_ack=1
mem_ack  in  1  read complete
ir  out  INSTR_W  instruction register
opcode  out  4  ir[15:12]
rd  out  2  ir[11:10]
rs  out  2  ir[9:8]
imm  out  8  ir[7:0]
pc  out  ADDR_W  program counter
en1  out  1  fetch done, one-cycle pulse, ir valid
busy  out  1  high in REQ and DONE
fetch_overrun  out  1  sticky: en_fetch_pulse arrived while busy
fetch_err  out  1  sticky: fetch timed out (feature only; else constant 0)

Behaviour:
- Reset (async): pc=RESET_PC; ir=0; mem_req=0; mem_addr=0; en1=0; busy=0; fetch_overrun=0; fetch_err=0; FSM to IDLE.
- If reset asserts mid-fetch, the fetch is abandoned. A late mem_ack after reset release is ignored in IDLE.
- Field outputs are combinational slices of ir.
- PC update runs independently of the FSM, on every edge where en_pc_pulse=1:
  - 01: pc <= pc+1, wrapping modulo 2^ADDR_W (max -> 0).
  - 10: pc <= ir[ADDR_W-1:0], zero-extended when ADDR_W>8.
  - 11: pc <= RESET_PC.
  - 00: hold.
  - en_pc_pulse=0: hold regardless of pc_ctrl.
- FSM states IDLE, REQ, DONE:
  - IDLE, en_fetch_pulse=1: mem_addr <= pc pre-update value (the value before any same-edge increment); go to REQ.
  - REQ: mem_req=1 and mem_addr held. On mem_ack=1: ir <= mem_rdata; go to DONE. mem_ack is ignored outside REQ.
  - DONE: en1=1 for exactly one cycle; mem_req=0; go to IDLE.
- Simultaneous en_fetch_pulse and en_pc_pulse with pc_ctrl=01 (normal control-unit Fetch entry): fetch address = old pc; pc = old pc+1.
- Zero-wait memory (ack in first REQ cycle): pulse edge N, mem_req high in cycle N+1, ir loaded at edge N+2, en1 high in cycle N+2, back in IDLE after N+3.
- en_fetch_pulse while in REQ or DONE: ignored, and fetch_overrun set (cleared only by reset).
- ir holds its value until the next successful fetch; a jump uses the current ir.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a wait counter clears on entry to REQ and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES with mem_ack still 0:
  - mem_req drops.
  - ir <= 16'hF000, an illegal opcode that parks the control unit in Decode.
  - fetch_err set (sticky); go to DONE, so en1 still pulses.
- An ack in the same cycle the counter hits the limit wins: normal load, no error.
- Undefined: no counter; REQ waits indefinitely; fetch_err tied to 0.

Test Plan:
- Reset with RESET_PC=0x10, then pulse en_fetch + en_pc (pc_ctrl=01), memory returns 16'h2A05 with 0 wait -> mem_addr=0x10, pc=0x11, ir=16'h2A05, opcode=2, rd=2, rs=2, imm=0x05, en1 high exactly 1 cycle, 2 cycles after the pulse edge.
- Memory ack delayed 3 cycles -> mem_req high 4 cycles with mem_addr stable; en1 once, after the ack.
- ir=16'hA033, pulse en_pc with pc_ctrl=10 -> pc=0x33; next fetch reads address 0x33. pc=0xFF with pc_ctrl=01 -> pc=0x00.
- en_fetch_pulse during REQ -> no second request, fetch_overrun=1; assert rst mid-REQ -> all outputs at reset values, late ack ignored.
- FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles ir=16'hF000, fetch_err=1, en1 pulses once. Ack on the 4th cycle -> normal load, fetch_err=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the program counter, runs a req/ack read
// to instruction memory, holds the fetched word in ir and decodes its fields
// for the control unit. en1 pulses for one cycle when ir is valid.
// Optional build macro: FETCH_TIMEOUT_EN (bounded memory wait, sticky fetch_err).
module instr_fetch_unit #(
    parameter int ADDR_W         = 8,
    parameter int INSTR_W        = 16,
    parameter int RESET_PC       = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_fetch_pulse,
    input  logic               en_pc_pulse,
    input  logic [1:0]         pc_ctrl,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               en1,
    output logic               busy,
    output logic               fetch_overrun,
    output logic               fetch_err
);

    // The field layout below is hard-wired to a 16-bit instruction word.
    if (INSTR_W != 16 || ADDR_W < 1 || ADDR_W > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("instr_fetch_unit: INSTR_W must be 16, ADDR_W 1..8, TIMEOUT_CYCLES >= 1");
    end

    localparam logic [ADDR_W-1:0]  PC_RESET_VAL  = RESET_PC[ADDR_W-1:0];
    // Illegal opcode 0xF parks the control unit in Decode after a failed fetch.
    localparam logic [INSTR_W-1:0] ILLEGAL_INSTR = INSTR_W'(16'hF000);

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;
    localparam logic [1:0] PC_RESET = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    logic start_fetch;   // IDLE accepts a fetch pulse this cycle
    logic load_ir;       // memory data captured this cycle
    logic timeout_hit;   // wait limit reached without ack this cycle
    logic timeout_now;   // wait limit condition, independent of state

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             fetch_err_q;

    // The current REQ cycle is the TIMEOUT_CYCLES-th one without an ack.
    assign timeout_now = ((int'(wait_cnt) + 1) >= TIMEOUT_CYCLES);

    // Count REQ cycles spent waiting; restart on every new request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (start_fetch) begin
            wait_cnt <= '0;
        end else if (state == REQ && !mem_ack && !timeout_now) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky record that a fetch was abandoned on timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_err_q <= 1'b0;
        end else if (timeout_hit) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    // Without the timeout the request waits for as long as memory needs.
    assign timeout_now = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // FSM state register; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ack only matters while a request is outstanding,
    // and an ack in the limit cycle takes priority over the timeout.
    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        load_ir     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (en_fetch_pulse) begin
                    start_fetch = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    load_ir   = 1'b1;
                    state_nxt = DONE;
                end else if (timeout_now) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_req = (state == REQ);
    assign en1     = (state == DONE);
    assign busy    = (state != IDLE);

    // Latch the fetch address from pc before any same-edge pc update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr <= '0;
        end else if (start_fetch) begin
            mem_addr <= pc;
        end
    end

    // Instruction register: loads on ack, or the illegal word on timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= '0;
        end else if (load_ir) begin
            ir <= mem_rdata;
        end else if (timeout_hit) begin
            ir <= ILLEGAL_INSTR;
        end
    end

    // Sticky flag for a fetch pulse that arrives while a fetch is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_overrun <= 1'b0;
        end else if (en_fetch_pulse && state != IDLE) begin
            fetch_overrun <= 1'b1;
        end
    end

    // Program counter, driven by the control unit independently of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_RESET_VAL;
        end else if (en_pc_pulse) begin
            case (pc_ctrl)
                PC_HOLD:  pc <= pc;
                PC_INC:   pc <= pc + ADDR_W'(1);
                PC_JUMP:  pc <= ir[ADDR_W-1:0];
                PC_RESET: pc <= PC_RESET_VAL;
                default:  pc <= pc;
            endcase
        end
    end

    assign opcode = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign imm    = ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (RESET_PC=0x10, TIMEOUT_CYCLES=4).
// Inputs change just after the falling edge; outputs are sampled on it.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en_fetch_pulse;
    logic        en_pc_pulse;
    logic [1:0]  pc_ctrl;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [7:0]  imm;
    logic [7:0]  pc;
    logic        en1;
    logic        busy;
    logic        fetch_overrun;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(
        .ADDR_W(8),
        .INSTR_W(16),
        .RESET_PC(16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en_fetch_pulse(en_fetch_pulse),
        .en_pc_pulse(en_pc_pulse),
        .pc_ctrl(pc_ctrl),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .ir(ir),
        .opcode(opcode),
        .rd(rd),
        .rs(rs),
        .imm(imm),
        .pc(pc),
        .en1(en1),
        .busy(busy),
        .fetch_overrun(fetch_overrun),
        .fetch_err(fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        en_fetch_pulse = 1'b0;
        en_pc_pulse = 1'b0;
        pc_ctrl = 2'b00;
        mem_rdata = 16'h0000;
        mem_ack = 1'b0;
        nxt();
        nxt();
        // Reset values
        chk("rst_pc", 16'(pc), 16'h0010);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_req", 16'(mem_req), 16'h0);
        chk("rst_addr", 16'(mem_addr), 16'h0000);
        chk("rst_en1", 16'(en1), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_ovr", 16'(fetch_overrun), 16'h0);
        chk("rst_err", 16'(fetch_err), 16'h0);
        rst = 1'b1;
        nxt();

        // Zero-wait fetch with simultaneous pc increment
        en_fetch_pulse = 1'b1;
        en_pc_pulse = 1'b1;
        pc_ctrl = 2'b01;
        nxt();
        chk("zw_req", 16'(mem_req), 16'h1);
        chk("zw_addr", 16'(mem_addr), 16'h0010);
        chk("zw_pc", 16'(pc), 16'h0011);
        chk("zw_en1_early", 16'(en1), 16'h0);
        chk("zw_busy", 16'(busy), 16'h1);
        en_fetch_pulse = 1'b0;
        en_pc_pulse = 1'b0;
        pc_ctrl = 2'b00;
        mem_ack = 1'b1;
        mem_rdata = 16'h2A05;
        nxt();
        mem_ack = 1'b0;
        chk("zw_en1", 16'(en1), 16'h1);
        chk("zw_ir", ir, 16'h2A05);
        chk("zw_opcode", 16'(opcode), 16'h2);
        chk("zw_rd", 16'(rd), 16'h2);
        chk("zw_rs", 16'(rs), 16'h2);
        chk("zw_imm", 16'(imm), 16'h05);
        chk("zw_req_done", 16'(mem_req), 16'h0);
        nxt();
        chk("zw_en1_off", 16'(en1), 16'h0);
        chk("zw_idle", 16'(busy), 16'h0);

        // Three wait states: request held four cycles with a stable address
        en_fetch_pulse = 1'b1;
        nxt();
        en_fetch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ws_req", 16'(mem_req), 16'h1);
            chk("ws_addr", 16'(mem_addr), 16'h0011);
            chk("ws_en1", 16'(en1), 16'h0);
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 16'hA033;
            end
            nxt();
        end
        mem_ack = 1'b0;
        chk("ws_en1_on", 16'(en1), 16'h1);
        chk("ws_ir", ir, 16'hA033);
        chk("ws_req_off", 16'(mem_req), 16'h0);
        nxt();
        chk("ws_en1_once", 16'(en1), 16'h0);

        // Jump to ir[7:0], then fetch from the jump target
        en_pc_pulse = 1'b1;
        pc_ctrl = 2'b10;
        nxt();
        en_pc_pulse = 1'b0;
        pc_ctrl = 2'b00;
        chk("jmp_pc", 16'(pc), 16'h0033);
        en_fetch_pulse = 1'b1;
        nxt();
        en_fetch_pulse = 1'b0;
        chk("jmp_addr", 16'(mem_addr), 16'h0033);
        mem_ack = 1'b1;
        mem_rdata = 16'h10FF;
        nxt();
        mem_ack = 1'b0;
        chk("jmp_ir", ir, 16'h10FF);
        nxt();

        // pc wrap, hold codes and reset-load code
        en_pc_pulse = 1'b1;
        pc_ctrl = 2'b10;
        nxt();
        chk("pc_ff", 16'(pc), 16'h00FF);
        pc_ctrl = 2'b01;
        nxt();
        chk("pc_wrap", 16'(pc), 16'h0000);
        pc_ctrl = 2'b00;
        nxt();
        chk("pc_hold00", 16'(pc), 16'h0000);
        en_pc_pulse = 1'b0;
        pc_ctrl = 2'b01;
        nxt();
        chk("pc_hold_noen", 16'(pc), 16'h0000);
        en_pc_pulse = 1'b1;
        pc_ctrl = 2'b11;
        nxt();
        en_pc_pulse = 1'b0;
        pc_ctrl = 2'b00;
        chk("pc_reset_ld", 16'(pc), 16'h0010);

        // Overrun during REQ, then reset mid-fetch with a late ack
        en_fetch_pulse = 1'b1;
        nxt();
        chk("ovr_pre", 16'(fetch_overrun), 16'h0);
        nxt();
        en_fetch_pulse = 1'b0;
        chk("ovr_set", 16'(fetch_overrun), 16'h1);
        chk("ovr_req", 16'(mem_req), 16'h1);
        chk("ovr_addr", 16'(mem_addr), 16'h0010);
        nxt();
        chk("ovr_sticky", 16'(fetch_overrun), 16'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 16'(mem_req), 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_ovr", 16'(fetch_overrun), 16'h0);
        chk("mid_rst_ir", ir, 16'h0000);
        chk("mid_rst_addr", 16'(mem_addr), 16'h0000);
        nxt();
        rst = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        nxt();
        nxt();
        mem_ack = 1'b0;
        chk("late_ack_ir", ir, 16'h0000);
        chk("late_ack_en1", 16'(en1), 16'h0);
        chk("late_ack_busy", 16'(busy), 16'h0);

`ifdef FETCH_TIMEOUT_EN
        // Ack in the limit cycle wins over the timeout
        en_fetch_pulse = 1'b1;
        nxt();
        en_fetch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_ack_req", 16'(mem_req), 16'h1);
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 16'h1234;
            end
            nxt();
        end
        mem_ack = 1'b0;
        chk("to_ack_en1", 16'(en1), 16'h1);
        chk("to_ack_ir", ir, 16'h1234);
        chk("to_ack_err", 16'(fetch_err), 16'h0);
        nxt();
        // No ack: after four REQ cycles the illegal word is loaded
        en_fetch_pulse = 1'b1;
        nxt();
        en_fetch_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 16'(mem_req), 16'h1);
            nxt();
        end
        chk("to_en1", 16'(en1), 16'h1);
        chk("to_ir", ir, 16'hF000);
        chk("to_err", 16'(fetch_err), 16'h1);
        chk("to_req_off", 16'(mem_req), 16'h0);
        nxt();
        chk("to_en1_once", 16'(en1), 16'h0);
        chk("to_err_sticky", 16'(fetch_err), 16'h1);
`else
        // Without the timeout a request waits indefinitely
        en_fetch_pulse = 1'b1;
        nxt();
        en_fetch_pulse = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nxt();
        end
        chk("wait_req", 16'(mem_req), 16'h1);
        chk("wait_en1", 16'(en1), 16'h0);
        chk("wait_err", 16'(fetch_err), 16'h0);
        mem_ack = 1'b1;
        mem_rdata = 16'h5A5A;
        nxt();
        mem_ack = 1'b0;
        chk("wait_ir", ir, 16'h5A5A);
        chk("wait_en1_on", 16'(en1), 16'h1);
        nxt();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
